// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues sequential word fetches to instruction memory under a credit scheme
// so that every in-flight request is guaranteed a slot in the instruction
// buffer. Redirects flush the buffer and arm a drop counter that discards
// the responses of requests issued before the redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  // Counters hold 0..DEPTH; pointers index 0..DEPTH-1.
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0]   buf_mem [DEPTH];
  logic          buf_we;

  logic          req_fire;
  logic          pop;
  logic          push;
  logic          rsp_drop;
  logic [CW:0]   credit_used;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // The slot being popped this cycle counts as free again, so a full
  // pipeline (one response landing, one instruction leaving) keeps issuing
  // and sustains one instruction per cycle at memory latency 1.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, count_q} - (CW + 1)'(pop);

  assign instr_valid    = (count_q != '0);
  assign pop            = instr_valid & instr_ready;
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_W);
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign rsp_drop       = imem_rsp_valid & (drop_cnt_q != '0);
  // A response landing in a redirect cycle belongs to the old stream.
  assign push           = imem_rsp_valid & (drop_cnt_q == '0) & !redirect_valid;

  assign imem_req_addr  = fetch_pc_q;
  assign instr          = buf_mem[rd_ptr_q];
  assign instr_pc       = head_pc_q;

  // Next-state logic: PCs, buffer occupancy, credit and drop accounting.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    head_pc_d     = head_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    buf_we        = 1'b0;

    // Every response retires one in-flight request, dropped or not.
    case ({req_fire, imem_rsp_valid})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (redirect_valid) begin
      // Flush: the buffer empties, both PCs jump to the aligned target and
      // everything still in flight (minus a response landing now) is dropped.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      head_pc_d  = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      drop_cnt_d = (imem_rsp_valid && (outstanding_q != '0)) ?
                   outstanding_q - CW'(1) : outstanding_q;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (push) begin
        buf_we   = 1'b1;
        wr_ptr_d = ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d  = ptr_next(rd_ptr_q);
        head_pc_d = head_pc_q + 32'd4;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      head_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      head_pc_q     <= head_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Instruction buffer storage; contents are qualified by count, so no reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_mem[wr_ptr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit with a
// behavioural in-order instruction memory and an expected-stream scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  // Memory image: upper half is the inverted lower address half.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // ---------------- expected instruction stream (scoreboard) ----------------
  typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;
  exp_t        exp_q[$];
  exp_t        e_v;
  logic [31:0] exp_next_pc = RESET_PC;

  function automatic void top_up();
    exp_t e;
    while (exp_q.size() < 16) begin
      e.pc   = exp_next_pc;
      e.word = mem_word(exp_next_pc);
      exp_q.push_back(e);
      exp_next_pc = exp_next_pc + 32'd4;
    end
  endfunction

  function automatic void restart_exp(input logic [31:0] pc);
    exp_q.delete();
    exp_next_pc = {pc[31:2], 2'b00};
    top_up();
  endfunction

  // ---------------- behavioural instruction memory ----------------
  typedef struct { int due; logic [31:0] addr; } pend_t;
  pend_t       pend_q[$];
  pend_t       p_v;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_v = 1;
  int          lat_fix = 1;
  bit          rand_mem = 1'b0;
  logic        hs_seen = 1'b0;
  logic [31:0] hs_addr = 32'h0;

  always @(negedge clk) begin
    hs_seen = !rst && imem_req_valid && imem_req_ready;
    hs_addr = imem_req_addr;
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      pend_q.delete();
      last_due       = cyc;
      imem_rsp_valid = 1'b0;
    end else begin
      if (hs_seen) begin
        lat_v  = rand_mem ? int'($urandom_range(1, 4)) : lat_fix;
        p_v.due  = cyc + lat_v - 1;
        if (p_v.due <= last_due) p_v.due = last_due + 1;
        last_due = p_v.due;
        p_v.addr = hs_addr;
        pend_q.push_back(p_v);
      end
      imem_rsp_valid = 1'b0;
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
        p_v            = pend_q.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(p_v.addr);
      end
      imem_req_ready = rand_mem ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    top_up();
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (instr_valid && instr_ready && !redirect_valid) begin
        checks++;
        pops++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_empty got pc=%h word=%h required=no instruction", instr_pc, instr);
        end else begin
          e_v = exp_q.pop_front();
          if (instr_pc !== e_v.pc || instr !== e_v.word) begin
            errors++;
            $display("FAIL stream got pc=%h word=%h required pc=%h word=%h",
                     instr_pc, instr, e_v.pc, e_v.word);
          end else begin
            $display("instr pc=%h word=%h", instr_pc, instr);
          end
        end
      end
      checks++;
      if (pend_q.size() > DEPTH) begin
        errors++;
        $display("FAIL inflight got=%0d required<=%0d", pend_q.size(), DEPTH);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    restart_exp(t);
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_valid && !redirect_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s got=no instr_valid required=instr_valid within 40 cycles", name);
    end
  endtask

  initial begin
    bit ok;
    int cnt;

    // Reset state.
    rst = 1'b1;
    instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_valid",   imem_req_valid, 32'd0);
    check("rst_instr_valid", instr_valid,    32'd0);
    check("rst_req_addr",    imem_req_addr,  RESET_PC);
    check("rst_instr_pc",    instr_pc,       RESET_PC);

    // Release: request same cycle, response next, instruction the one after.
    tick();
    rst = 1'b0;
    restart_exp(RESET_PC);
    @(negedge clk);
    check("c0_req_valid",   imem_req_valid, 32'd1);
    check("c0_req_addr",    imem_req_addr,  32'h0000_0000);
    check("c0_instr_valid", instr_valid,    32'd0);
    @(negedge clk);
    check("c1_rsp_valid",   imem_rsp_valid, 32'd1);
    check("c1_instr_valid", instr_valid,    32'd0);
    @(negedge clk);
    check("c2_instr_valid", instr_valid,    32'd1);
    check("c2_instr_pc",    instr_pc,       32'h0000_0000);
    check("c2_instr",       instr,          32'hFFFF_0000);

    // Sustained one instruction per cycle.
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid) cnt++;
    end
    check("rate_20_cycles", 32'(cnt), 32'd20);

    // Consumer stall: buffer fills, fetch stops with nothing in flight.
    tick();
    instr_ready = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check("stall_req_valid",   imem_req_valid, 32'd0);
    check("stall_instr_valid", instr_valid,    32'd1);
    check("stall_inflight",    32'(pend_q.size()) + 32'(imem_rsp_valid), 32'd0);
    tick();
    instr_ready = 1'b1;
    repeat (10) tick();

    // Redirect to an unaligned target with requests in flight.
    lat_fix = 4;
    repeat (12) tick();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pend_q.size() == 2) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drop_setup got=fewer in flight required=2 in flight");
    end
    tick();
    do_redirect(32'h0000_0103);
    tick();
    redirect_valid = 1'b0;
    wait_valid("drop_first", ok);
    if (ok) begin
      check("drop_first_pc",    instr_pc, 32'h0000_0100);
      check("drop_first_instr", instr,    32'hFEFF_0100);
    end
    lat_fix = 1;
    repeat (10) tick();

    // Redirect coincident with a pop and a response.
    tick();
    do_redirect(32'h0000_0200);
    @(negedge clk);
    check("coinc_pop", instr_valid & instr_ready, 32'd1);
    check("coinc_rsp", imem_rsp_valid,            32'd1);
    tick();
    redirect_valid = 1'b0;
    wait_valid("coinc_first", ok);
    if (ok) begin
      check("coinc_first_pc",    instr_pc, 32'h0000_0200);
      check("coinc_first_instr", instr,    32'hFDFF_0200);
    end
    repeat (6) tick();

    // Back-to-back redirects: the second target wins.
    tick();
    do_redirect(32'h0000_0300);
    tick();
    do_redirect(32'h0000_0404);
    tick();
    redirect_valid = 1'b0;
    wait_valid("b2b_first", ok);
    if (ok) begin
      check("b2b_first_pc",    instr_pc, 32'h0000_0404);
      check("b2b_first_instr", instr,    32'hFBFB_0404);
    end
    repeat (6) tick();

    // Address wrap at the top of the address space.
    tick();
    do_redirect(32'hFFFF_FFF9);
    @(negedge clk);
    check("wrap_redirect_req_valid", imem_req_valid, 32'd0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("wrap_addr0", imem_req_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    check("wrap_addr1", imem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_addr2", imem_req_addr, 32'h0000_0000);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid && instr_pc == 32'h0000_0000) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) check("wrap_instr", instr, 32'hFFFF_0000);
    else begin
      checks++;
      errors++;
      $display("FAIL wrap_pc got=no instr_pc 0 required=instr_pc 00000000 within 20 cycles");
    end
    repeat (4) tick();

    // Randomized memory readiness/latency, consumer stalls and redirects.
    rand_mem = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      instr_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 39) == 0) do_redirect($urandom);
      else redirect_valid = 1'b0;
    end
    tick();
    redirect_valid = 1'b0;
    rand_mem       = 1'b0;
    instr_ready    = 1'b1;
    repeat (30) tick();
    check("random_progress", 32'(pops > 300), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
